wavuno_ram_arbiter: RTL and testbench

- Time-division arbiter for the WavUno sample RAM.
- Shares one single-port synchronous RAM between the Z80 register-port path and NUM_CH playback channels.
- Generates the 8-phase frame, reserves turbo-dependent CPU windows and executes exactly one RAM access per CPU request edge. Remaining phases go round-robin to the channels.
- Sits between the Z80 register decoder / channel sequencers and the RAM macro.

---
 rtl/wavuno_pkg.sv | 41 ++++
 rtl/wavuno_rr_picker.sv | 36 +++
 rtl/wavuno_ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_wavuno_ram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavuno_pkg.sv
// WavUno shared definitions: frame geometry, turbo encodings and the
// per-turbo CPU-phase / window-start masks used by the RAM arbiter.
// No ports; imported by wavuno_ram_arbiter and its sub-modules.
package wavuno_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [1:0] {
    TURBO_3M5     = 2'd0,
    TURBO_7M      = 2'd1,
    TURBO_14M     = 2'd2,
    TURBO_14M_ALT = 2'd3
  } turbo_e;

  // Bit n set means frame phase n belongs to the CPU.
  localparam logic [7:0] CPU_MASK_3M5 = 8'h0F;
  localparam logic [7:0] CPU_MASK_7M  = 8'h33;
  localparam logic [7:0] CPU_MASK_14M = 8'h55;

  // Bit n set means a CPU window opens at phase n.
  localparam logic [7:0] WIN_MASK_3M5 = 8'h01;
  localparam logic [7:0] WIN_MASK_7M  = 8'h11;
  localparam logic [7:0] WIN_MASK_14M = 8'h55;

  function automatic logic [7:0] cpuPhaseMask(input turbo_e turbo);
    case (turbo)
      TURBO_3M5: return CPU_MASK_3M5;
      TURBO_7M:  return CPU_MASK_7M;
      default:   return CPU_MASK_14M;
    endcase
  endfunction

  function automatic logic [7:0] winStartMask(input turbo_e turbo);
    case (turbo)
      TURBO_3M5: return WIN_MASK_3M5;
      TURBO_7M:  return WIN_MASK_7M;
      default:   return WIN_MASK_14M;
    endcase
  endfunction

endpackage

// File: rtl/wavuno_rr_picker.sv
// Combinational round-robin picker for the playback channels.
// Ports:
//   req     - per-channel request vector
//   last    - index of the most recently granted channel
//   pick    - one-hot selection (first requester after last, wrapping)
//   pickIdx - binary index of pick
//   valid   - at least one request present
module wavuno_rr_picker #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NUM_CH-1:0] pick,
  output logic [IDX_W-1:0]  pickIdx,
  output logic              valid
);

  always_comb begin
    // NOTE: every output gets a default before the search loop, so no path
    // leaves a value unassigned and no latch is inferred.
    pick    = '0;
    pickIdx = '0;
    valid   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(last) + k) % NUM_CH;
      if (!valid && req[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
        pickIdx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wavuno_ram_arbiter.sv
// Time-division arbiter for the WavUno sample RAM. An 8-phase frame is
// split into CPU phases (turbo dependent, reserved even when idle) and
// channel phases served round-robin. One RAM access per Z80 request edge.
// Ports:
//   clk28, rst             - clock, synchronous active-high reset
//   turbo_enable           - CPU speed, latched at phase 7
//   cpu_req/we/addr/wdata  - Z80 data-port access (cpu_req is a level)
//   cpu_ack, cpu_rdata     - completion pulse and read data (held)
//   ch_req, ch_addr        - per-channel read requests and packed addresses
//   ch_grant, ch_rdata     - one-hot grant pulse and read data (held)
//   ram_addr/we/wdata/rdata- single-port synchronous RAM, 1-cycle read
//   phase                  - current frame phase
module wavuno_ram_arbiter
  import wavuno_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 11
) (
  input  logic                     clk28,
  input  logic                     rst,
  input  logic [1:0]               turbo_enable,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [7:0]               cpu_wdata,
  output logic                     cpu_ack,
  output logic [7:0]               cpu_rdata,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [7:0]               ch_rdata,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [7:0]               ram_wdata,
  input  logic [7:0]               ram_rdata,
  output logic [PHASE_W-1:0]       phase
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PHASE_W-1:0] phaseQ;
  turbo_e             turboQ;
  logic               pending;
  logic               armed;
  logic [IDX_W-1:0]   rrLast;
  logic               cpuAckQ;
  logic               cpuReadQ;
  logic [7:0]         cpuRdataQ;
  logic [NUM_CH-1:0]  chGrantQ;
  logic [7:0]         chRdataQ;

  logic [7:0]         cpuMaskNow;
  logic [7:0]         winMaskNow;
  logic               cpuPhase;
  logic               winStart;
  logic               cpuEdge;
  logic               cpuServe;
  logic               chServe;
  logic [NUM_CH-1:0]  pick;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickValid;
  logic [ADDR_W-1:0]  chAddrArr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_addr
    assign chAddrArr[i] = ch_addr[i*ADDR_W +: ADDR_W];
  end

  wavuno_rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
    .req     (ch_req),
    .last    (rrLast),
    .pick    (pick),
    .pickIdx (pickIdx),
    .valid   (pickValid)
  );

  assign cpuMaskNow = cpuPhaseMask(turboQ);
  assign winMaskNow = winStartMask(turboQ);
  assign cpuPhase   = cpuMaskNow[phaseQ];
  assign winStart   = winMaskNow[phaseQ];
  assign cpuEdge    = cpu_req && armed;

  // pending is registered, so an edge captured in a window-start cycle is
  // only seen by the next window start. Reset forces the RAM port idle.
  assign cpuServe = !rst && winStart && pending;
  assign chServe  = !rst && !cpuPhase && pickValid;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (cpuServe) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (chServe) begin
      ram_addr  = chAddrArr[pickIdx];
    end
  end

  always_ff @(posedge clk28) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      phaseQ    <= '0;
      turboQ    <= TURBO_3M5;
      pending   <= 1'b0;
      armed     <= 1'b1;
      rrLast    <= IDX_W'(NUM_CH - 1);
      cpuAckQ   <= 1'b0;
      cpuReadQ  <= 1'b0;
      cpuRdataQ <= '0;
      chGrantQ  <= '0;
      chRdataQ  <= '0;
    end else begin
      phaseQ <= phaseQ + PHASE_W'(1);
      if (phaseQ == PHASE_W'(7)) turboQ <= turbo_e'(turbo_enable);

      // A new edge wins over clearing: it is a distinct Z80 access.
      if (cpuEdge) begin
        pending <= 1'b1;
        armed   <= 1'b0;
      end else begin
        if (cpuServe) pending <= 1'b0;
        if (!cpu_req) armed <= 1'b1;
      end

      cpuAckQ  <= cpuServe;
      cpuReadQ <= cpuServe && !cpu_we;
      if (cpuAckQ && cpuReadQ) cpuRdataQ <= ram_rdata;

      chGrantQ <= chServe ? pick : '0;
      if (chServe) rrLast <= pickIdx;
      if (|chGrantQ) chRdataQ <= ram_rdata;
    end
  end

  // Read data passes straight through in the completion cycle (RAM has one
  // cycle of latency) and is held from the register afterwards. Completion
  // pulses are masked in a reset cycle so a reset mid-access drops it.
  assign cpu_ack   = cpuAckQ && !rst;
  assign ch_grant  = rst ? '0 : chGrantQ;
  assign cpu_rdata = (cpu_ack && cpuReadQ) ? ram_rdata : cpuRdataQ;
  assign ch_rdata  = (|ch_grant) ? ram_rdata : chRdataQ;
  assign phase     = phaseQ;

endmodule

// File: tb/tb_wavuno_ram_arbiter.sv
// Directed bench for wavuno_ram_arbiter with a behavioural 2K x 8 RAM.
// Unwritten RAM locations read as (addr[7:0] ^ 8'h5A).
module tb_wavuno_ram_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 11;

  logic                     clk28 = 1'b0;
  logic                     rst;
  logic [1:0]               turbo_enable;
  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [7:0]               cpu_wdata;
  logic                     cpu_ack;
  logic [7:0]               cpu_rdata;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_grant;
  logic [7:0]               ch_rdata;
  logic [ADDR_W-1:0]        ram_addr;
  logic                     ram_we;
  logic [7:0]               ram_wdata;
  logic [7:0]               ram_rdata;
  logic [2:0]               phase;

  int checks = 0;
  int errors = 0;

  wavuno_ram_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk28        (clk28),
    .rst          (rst),
    .turbo_enable (turbo_enable),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .ch_req       (ch_req),
    .ch_addr      (ch_addr),
    .ch_grant     (ch_grant),
    .ch_rdata     (ch_rdata),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .phase        (phase)
  );

  always #5 clk28 = ~clk28;

  // RAM model
  logic [7:0] mem     [2048];
  logic       written [2048];
  always @(posedge clk28) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] === 1'b1 ? mem[ram_addr] : (ram_addr[7:0] ^ 8'h5A);
  end

  task automatic step();
    @(posedge clk28);
    @(negedge clk28);
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n;
    n = 0;
    step();
    while (phase !== p && n < 16) begin
      step();
      n++;
    end
    checks++;
    if (phase !== p) begin
      errors++;
      $display("FAIL wait_phase timeout: phase=%0d want=%0d", phase, p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; turbo_enable = 2'd0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; ch_req = '0;
    ch_addr = {11'h103, 11'h102, 11'h101, 11'h100};
    repeat (2) @(posedge clk28);
    @(negedge clk28);
    checks++;
    if (phase !== 3'd0 || cpu_ack !== 1'b0 || ch_grant !== 4'b0 || ram_we !== 1'b0 ||
        ram_addr !== 11'h0 || ram_wdata !== 8'h0 || cpu_rdata !== 8'h0 || ch_rdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: phase=%0d ack=%b grant=%b we=%b addr=%h wd=%h crd=%h chrd=%h want all zero",
               phase, cpu_ack, ch_grant, ram_we, ram_addr, ram_wdata, cpu_rdata, ch_rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_phase: got %0d want 0", phase);
    end
  endtask

  // turbo 0 write held 20 cycles: one write at phase 0, one ack at phase 1
  task automatic test_cpu_write();
    int weCount, ackCount;
    logic [2:0] wePhase, ackPhase;
    logic [10:0] weAddr;
    logic [7:0] weData;
    weCount = 0; ackCount = 0; wePhase = 3'd7; ackPhase = 3'd7; weAddr = '0; weData = '0;
    cpu_we = 1'b1; cpu_addr = 11'h005; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ram_we === 1'b1) begin
        weCount++; wePhase = phase; weAddr = ram_addr; weData = ram_wdata;
      end
      if (cpu_ack === 1'b1) begin
        ackCount++; ackPhase = phase;
      end
    end
    cpu_req = 1'b0;
    checks++;
    if (weCount != 1) begin errors++; $display("FAIL write_count: got %0d want 1", weCount); end
    checks++;
    if (wePhase !== 3'd0) begin errors++; $display("FAIL write_phase: got %0d want 0", wePhase); end
    checks++;
    if (weAddr !== 11'h005 || weData !== 8'hA5) begin
      errors++; $display("FAIL write_bus: addr=%h data=%h want 005/a5", weAddr, weData);
    end
    checks++;
    if (ackCount != 1 || ackPhase !== 3'd1) begin
      errors++; $display("FAIL write_ack: count=%0d phase=%0d want 1 at phase 1", ackCount, ackPhase);
    end
  endtask

  // turbo 2 read: issue at the next even phase, ack one cycle later
  task automatic test_cpu_read_turbo2();
    turbo_enable = 2'd2; cpu_we = 1'b0; cpu_addr = 11'h005;
    wait_phase(3'd7);
    wait_phase(3'd1);
    cpu_req = 1'b1;
    step();
    checks++;
    if (phase !== 3'd2 || ram_addr !== 11'h005 || ram_we !== 1'b0) begin
      errors++; $display("FAIL read_issue: phase=%0d addr=%h we=%b want 2/005/0", phase, ram_addr, ram_we);
    end
    step();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
      errors++; $display("FAIL read_ack: ack=%b rdata=%h want 1/a5", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    step();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5) begin
      errors++; $display("FAIL read_hold: ack=%b rdata=%h want 0/a5", cpu_ack, cpu_rdata);
    end
  endtask

  // turbo 0, all channels requesting: selections at phases 4..7, grants one cycle later
  task automatic test_channel_rr();
    logic [10:0] expAddr  [8];
    logic [3:0]  expGrant [8];
    logic [7:0]  expRd    [8];
    logic [2:0]  ph;
    expAddr  = '{11'h0, 11'h0, 11'h0, 11'h0, 11'h100, 11'h101, 11'h102, 11'h103};
    expGrant = '{4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0010, 4'b0100};
    expRd    = '{8'h59, 8'h0, 8'h0, 8'h0, 8'h0, 8'h5A, 8'h5B, 8'h58};
    turbo_enable = 2'd0;
    wait_phase(3'd7);
    wait_phase(3'd0);
    ch_req = 4'b1111;
    for (int k = 1; k <= 16; k++) begin
      step();
      ph = 3'(k);
      checks++;
      if (phase !== ph || ram_addr !== expAddr[ph] || ram_we !== 1'b0) begin
        errors++; $display("FAIL rr_addr k=%0d: phase=%0d addr=%h we=%b want %0d/%h/0",
                           k, phase, ram_addr, ram_we, ph, expAddr[ph]);
      end
      checks++;
      if (ch_grant !== expGrant[ph]) begin
        errors++; $display("FAIL rr_grant k=%0d: got %b want %b", k, ch_grant, expGrant[ph]);
      end
      if (expGrant[ph] != 4'b0) begin
        checks++;
        if (ch_rdata !== expRd[ph]) begin
          errors++; $display("FAIL rr_rdata k=%0d: got %h want %h", k, ch_rdata, expRd[ph]);
        end
      end
    end
    ch_req = 4'b0000;
  endtask

  // turbo 0 -> 1 requested at phase 2: mask switches only at the frame boundary
  task automatic test_turbo_switch();
    logic [15:0] expCpu;
    logic [10:0] want;
    expCpu = 16'h330F;
    wait_phase(3'd2);
    turbo_enable = 2'd1;
    ch_req = 4'b0001;
    #1;
    checks++;
    if (ram_addr !== 11'h0) begin
      errors++; $display("FAIL turbo_k2: addr=%h want 000", ram_addr);
    end
    for (int k = 3; k <= 15; k++) begin
      step();
      want = expCpu[k] ? 11'h0 : 11'h100;
      checks++;
      if (ram_addr !== want) begin
        errors++; $display("FAIL turbo_mask k=%0d phase=%0d: addr=%h want %h", k, phase, ram_addr, want);
      end
    end
    ch_req = 4'b0000;
  endtask

  // turbo 1: CPU edge at phase 0 served at phase 4, ch2 selected at phase 2
  task automatic test_cpu_vs_channel();
    wait_phase(3'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
    ch_req = 4'b0100;
    #1;
    checks++;
    if (ram_addr !== 11'h0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL edge_same_window: addr=%h we=%b want 000/0", ram_addr, ram_we);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (cpu_ack === 1'b1 && ch_grant !== 4'b0) begin
        errors++; $display("FAIL ack_grant_overlap k=%0d: ack=%b grant=%b", k, cpu_ack, ch_grant);
      end
      case (k)
        1: begin
          checks++;
          if (ram_addr !== 11'h0 || cpu_ack !== 1'b0) begin
            errors++; $display("FAIL idle_cpu_phase: addr=%h ack=%b want 000/0", ram_addr, cpu_ack);
          end
        end
        2: begin
          checks++;
          if (ram_addr !== 11'h102 || ram_we !== 1'b0) begin
            errors++; $display("FAIL ch2_select: addr=%h we=%b want 102/0", ram_addr, ram_we);
          end
        end
        3: begin
          checks++;
          if (ch_grant !== 4'b0100 || ch_rdata !== 8'h58) begin
            errors++; $display("FAIL ch2_grant: grant=%b rdata=%h want 0100/58", ch_grant, ch_rdata);
          end
          ch_req = 4'b0000;
        end
        4: begin
          checks++;
          if (ram_addr !== 11'h005 || ram_we !== 1'b0) begin
            errors++; $display("FAIL cpu_phase4: addr=%h we=%b want 005/0", ram_addr, ram_we);
          end
        end
        5: begin
          checks++;
          if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            errors++; $display("FAIL cpu_ack5: ack=%b rdata=%h want 1/a5", cpu_ack, cpu_rdata);
          end
          cpu_req = 1'b0;
        end
        default: begin
          checks++;
          if (cpu_ack !== 1'b0) begin
            errors++; $display("FAIL extra_ack k=%0d: ack=%b want 0", k, cpu_ack);
          end
        end
      endcase
    end
  endtask

  // reset in the ack cycle of a write: no ack, everything zero afterwards
  task automatic test_reset_mid_access();
    wait_phase(3'd1);
    cpu_we = 1'b1; cpu_addr = 11'h006; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    repeat (3) step();
    checks++;
    if (phase !== 3'd4 || ram_we !== 1'b1 || ram_addr !== 11'h006 || ram_wdata !== 8'h3C) begin
      errors++; $display("FAIL mid_issue: phase=%0d we=%b addr=%h wd=%h want 4/1/006/3c",
                         phase, ram_we, ram_addr, ram_wdata);
    end
    @(posedge clk28);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk28);
    checks++;
    if (cpu_ack !== 1'b0 || ch_grant !== 4'b0) begin
      errors++; $display("FAIL mid_ack_dropped: ack=%b grant=%b want 0/0", cpu_ack, ch_grant);
    end
    @(posedge clk28);
    #1;
    rst = 1'b0;
    @(negedge clk28);
    checks++;
    if (phase !== 3'd0 || cpu_ack !== 1'b0 || ch_grant !== 4'b0 || ram_we !== 1'b0 ||
        ram_addr !== 11'h0 || ram_wdata !== 8'h0 || cpu_rdata !== 8'h0 || ch_rdata !== 8'h0) begin
      errors++; $display("FAIL post_reset: phase=%0d ack=%b grant=%b we=%b addr=%h wd=%h crd=%h chrd=%h want all zero",
                         phase, cpu_ack, ch_grant, ram_we, ram_addr, ram_wdata, cpu_rdata, ch_rdata);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet k=%0d: ack=%b we=%b want 0/0", k, cpu_ack, ram_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read_turbo2();
    test_channel_rr();
    test_turbo_switch();
    test_cpu_vs_channel();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
